// File: rtl/fofir_psum_requant.sv
// Requantizes 24-bit signed partial sums to 16-bit activations: round-half-up shift, optional ReLU, saturate.
// Two-stage valid/ready pipeline (input handshake -> out_valid two cycles later), framed by an IDLE/RUN/DRAIN FSM.
module fofir_psum_requant #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        cfg_len,
    input  logic [4:0]              cfg_shift,
    input  logic                    cfg_relu,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_psum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_act,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [4:0]             SH_MAX  = 5'(IN_W - 1);
    localparam logic signed [IN_W:0]   SAT_MAX = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0]   SAT_MIN = -(IN_W+1)'(2 ** (OUT_W - 1));

    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_len;
    logic [4:0]               r_shift;
    logic                     r_relu;
    logic                     r_done;

    logic                     r_s1_vld;
    logic signed [IN_W:0]     r_s1_dat;
    logic                     r_s1_last;

    logic                     r_s2_vld;
    logic signed [OUT_W-1:0]  r_s2_dat;
    logic                     r_s2_last;

    logic                     w_s2_free;
    logic                     w_s1_free;
    logic                     w_in_hs;
    logic                     w_out_hs;
    logic                     w_last_in;
    logic                     w_start_ok;
    logic                     w_start_zero;
    logic                     w_done_nxt;
    logic [IN_W:0]            w_rnd;
    logic signed [IN_W:0]     w_sum;
    logic signed [IN_W:0]     w_shr;
    logic signed [IN_W:0]     w_relu_dat;
    logic signed [IN_W:0]     w_sat_dat;

    assign w_s2_free    = !r_s2_vld || out_ready;
    assign w_s1_free    = !r_s1_vld || w_s2_free;
    assign in_ready     = (r_state == RUN) && w_s1_free;
    assign w_in_hs      = in_valid && in_ready;
    assign w_out_hs     = r_s2_vld && out_ready;
    assign w_last_in    = (r_cnt == r_len - CNT_W'(1));
    assign w_start_ok   = (r_state == IDLE) && start && (cfg_len != '0);
    assign w_start_zero = (r_state == IDLE) && start && (cfg_len == '0);
    assign w_done_nxt   = w_start_zero || ((r_state == DRAIN) && w_out_hs && r_s2_last);

    // 2^(shift-1) as the rounding bias; shift of zero yields no bias.
    assign w_rnd = ({{IN_W{1'b0}}, 1'b1} << r_shift) >> 1;
    assign w_sum = $signed({in_psum[IN_W-1], in_psum}) + $signed(w_rnd);
    assign w_shr = w_sum >>> r_shift;

    assign w_relu_dat = (r_relu && r_s1_dat[IN_W]) ? '0 : r_s1_dat;

    always_comb begin
        w_sat_dat = w_relu_dat;
        if (w_relu_dat > SAT_MAX) begin
            w_sat_dat = SAT_MAX;
        end else if (w_relu_dat < SAT_MIN) begin
            w_sat_dat = SAT_MIN;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = RUN;
            RUN:     if (w_in_hs && w_last_in) w_state_nxt = DRAIN;
            DRAIN:   if (w_out_hs && r_s2_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_start_ok) begin
                r_cnt   <= '0;
                r_len   <= cfg_len;
                r_shift <= (cfg_shift > SH_MAX) ? SH_MAX : cfg_shift;
                r_relu  <= cfg_relu;
            end else if (w_in_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1 refills only when it is empty or handing its item to stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_dat  <= '0;
            r_s1_last <= 1'b0;
        end else if (w_s1_free) begin
            r_s1_vld <= w_in_hs;
            if (w_in_hs) begin
                r_s1_dat  <= w_shr;
                r_s1_last <= w_last_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_dat  <= '0;
            r_s2_last <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_dat  <= w_sat_dat[OUT_W-1:0];
                r_s2_last <= r_s1_last;
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_act   = r_s2_dat;
    assign out_last  = r_s2_last;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_fofir_psum_requant.sv
// Directed bench for fofir_psum_requant: single-value vector table plus streaming, stall, zero-length and reset sequences.
module tb_fofir_psum_requant;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [15:0]        cfg_len;
    logic [4:0]         cfg_shift;
    logic               cfg_relu;
    logic               in_valid;
    logic               in_ready;
    logic signed [23:0] in_psum;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_act;
    logic               out_last;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int psum;
        int shift;
        bit relu;
        int exp_act;
    } vec_t;

    fofir_psum_requant dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulses start, then scrambles cfg_* to show they were latched.
    task automatic start_frame(input int len, input int sh, input bit relu);
        @(negedge clk);
        start = 1'b1; cfg_len = 16'(len); cfg_shift = 5'(sh); cfg_relu = relu;
        @(negedge clk);
        start = 1'b0; cfg_len = 16'd7; cfg_shift = 5'd0; cfg_relu = ~relu;
    endtask

    task automatic run1(input string tag, input int p, input int sh, input bit relu, input int exp);
        start_frame(1, sh, relu);
        in_valid = 1'b1; in_psum = 24'(p); out_ready = 1'b1;
        #1 chk({tag, " busy"}, busy, 1);
        chk({tag, " in_ready"}, in_ready, 1);
        @(negedge clk); in_valid = 1'b0;
        #1 chk({tag, " out_valid t+1"}, out_valid, 0);
        @(negedge clk); #1;
        chk({tag, " out_valid t+2"}, out_valid, 1);
        chk({tag, " out_act"}, out_act, exp);
        chk({tag, " out_last"}, out_last, 1);
        chk({tag, " done early"}, done, 0);
        @(negedge clk); #1;
        chk({tag, " done"}, done, 1);
        chk({tag, " busy low"}, busy, 0);
        chk({tag, " out_valid after"}, out_valid, 0);
        @(negedge clk); #1;
        chk({tag, " done one cycle"}, done, 0);
    endtask

    initial begin
        vec_t vt[13];
        int   sv[4];
        int   se[4];
        int   bq[3];
        int   exp_q[$];
        int   idx;
        int   n_out;
        int   prev_act;
        bit   prev_stall;
        bit   seen_done;
        bit   hs_in;
        bit   hs_out;

        vt[0]  = '{384, 8, 0, 2};
        vt[1]  = '{-384, 8, 0, -1};
        vt[2]  = '{8388607, 8, 0, 32767};
        vt[3]  = '{-8388608, 8, 0, -32768};
        vt[4]  = '{-5000, 0, 1, 0};
        vt[5]  = '{5000, 0, 1, 5000};
        vt[6]  = '{-5000, 0, 0, -5000};
        vt[7]  = '{4194304, 31, 0, 1};
        vt[8]  = '{256, 8, 0, 1};
        vt[9]  = '{-8388608, 0, 0, -32768};
        vt[10] = '{100, 1, 0, 50};
        vt[11] = '{-3, 1, 0, -1};
        vt[12] = '{-8388608, 0, 1, 0};

        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_shift = '0; cfg_relu = 1'b0;
        in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
        #12;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_act", out_act, 0);
        chk("reset out_last", out_last, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run1($sformatf("vec%0d", i), vt[i].psum, vt[i].shift, vt[i].relu, vt[i].exp_act);
        end

        // Back-to-back stream, len=4, shift=8: one output per cycle, last only on the 4th.
        sv = '{384, -384, 8388607, -8388608};
        se = '{2, -1, 32767, -32768};
        start_frame(4, 8, 0);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = (c < 4); in_psum = (c < 4) ? 24'(sv[c]) : '0; out_ready = 1'b1;
            #1;
            if (c < 4) chk($sformatf("stream in_ready c%0d", c), in_ready, 1);
            chk($sformatf("stream out_valid c%0d", c), out_valid, (c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) begin
                chk($sformatf("stream out_act c%0d", c), out_act, se[c-2]);
                chk($sformatf("stream out_last c%0d", c), out_last, (c == 5));
            end
            chk($sformatf("stream done c%0d", c), done, (c == 6));
        end
        in_valid = 1'b0;

        // Backpressure: out_ready low for the first 5 data cycles, in_valid held high.
        bq = '{10, 20, 30};
        start_frame(3, 0, 0);
        idx = 0; n_out = 0; prev_stall = 0; prev_act = 0; seen_done = 0;
        for (int c = 0; c < 30 && !seen_done; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = (idx < 3); in_psum = (idx < 3) ? 24'(bq[idx]) : '0;
            out_ready = (c >= 5);
            #1;
            if (c >= 2 && c <= 4) chk($sformatf("bp in_ready low c%0d", c), in_ready, 0);
            if (prev_stall) chk($sformatf("bp stable c%0d", c), out_act, prev_act);
            if (done) seen_done = 1;
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                n_out++;
                if (exp_q.size() == 0) chk("bp unexpected output", 1, 0);
                else chk($sformatf("bp out_act #%0d", n_out), out_act, exp_q.pop_front());
                chk($sformatf("bp out_last #%0d", n_out), out_last, (n_out == 3));
            end
            if (hs_in) begin
                exp_q.push_back(bq[idx]);
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_act   = int'(out_act);
        end
        chk("bp done seen", seen_done, 1);
        chk("bp output count", n_out, 3);
        in_valid = 1'b0;

        // Zero-length frame.
        @(negedge clk);
        start = 1'b1; cfg_len = '0;
        @(negedge clk);
        start = 1'b0;
        #1 chk("zero done", done, 1);
        chk("zero busy", busy, 0);
        chk("zero in_ready", in_ready, 0);
        chk("zero out_valid", out_valid, 0);
        @(negedge clk);
        #1 chk("zero done one cycle", done, 0);

        // Reset mid-frame after two accepted inputs.
        start_frame(4, 8, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_psum = 24'd512;
        @(negedge clk);
        in_psum = 24'd768;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst done", done, 0);
        @(negedge clk);
        #1 chk("rst hold done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        #1 chk("post rst done", done, 0);
        chk("post rst out_valid", out_valid, 0);
        run1("after rst", 256, 8, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fofir_psum_requant.md
# fofir_psum_requant

Output-side requantizer for the FoFIR PE array. The MACs widen 16-bit activations into 24-bit saturated partial sums; this block reads finished 24-bit partial sums and converts them back to 16-bit activations for the next layer's A operand. Conversion is round-half-up arithmetic right shift, optional ReLU, then saturation to 16 bits. It runs as a 2-stage valid/ready pipeline, framed by a start/done control FSM.

## Interface
- IN_W, 24, partial-sum width (signed)
- OUT_W, 16, activation width (signed)
- CNT_W, 16, frame-length counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- start  in  1  one-cycle frame start pulse, sampled in IDLE only
- cfg_len  in  CNT_W  outputs per frame, unsigned
- cfg_shift  in  5  right-shift amount; values >23 are clamped to 23
- cfg_relu  in  1  1 = negative results forced to 0
- in_valid  in  1  partial sum valid
- in_ready  out  1  block accepts partial sum
- in_psum  in  IN_W  signed partial sum
- out_valid  out  1  activation valid
- out_ready  in  1  downstream accepts activation
- out_act  out  OUT_W  signed activation
- out_last  out  1  marks the final activation of a frame
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle frame-complete pulse

## Operation
- **IDLE:** in_ready=0.
  - start with cfg_len≠0: latch cfg_len, cfg_shift (clamped) and cfg_relu, clear the input counter, go to RUN.
  - start with cfg_len=0: pulse done, stay in IDLE.
- **RUN:** accept inputs on in_valid&&in_ready and count them. The input accepted when count reaches the latched length carries a last tag; on that handshake go to DRAIN.
- **DRAIN:** in_ready=0. Go to IDLE on the handshake of the output with out_last; done pulses in the following cycle.
- start in RUN or DRAIN is ignored. cfg_* changes after start have no effect until the next frame.
- **Stage 1 (round/shift):** s = psum sign-extended to 25 bits. If shift>0, add 2^(shift-1) (round half toward +inf). Then arithmetic shift right by shift. No overflow is possible at 25 bits.
- **Stage 2 (relu/saturate):** if relu and the value is negative, use 0. Then clamp to [-32768, 32767]. The result is registered into out_act/out_last.
- **Flow control:**
  - Each stage advances when its successor is empty or advancing.
  - in_ready = RUN && (stage 1 empty || stage 1 advancing).
  - No bubbles under continuous traffic; no loss or duplication under any out_ready pattern.
  - out_act and out_last stay stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0, out_valid=0, out_act=0, out_last=0, busy=0, done=0, FSM=IDLE, counter=0, both pipeline stages empty.
- Latency: an input handshake at cycle t gives out_valid at t+2 when out_ready is held high.
- Throughput: 1 activation per cycle.
- busy rises the cycle after an accepted start. busy falls in the same cycle done is high.
- done is high for exactly one cycle: the cycle after the final out handshake, or the cycle after start when cfg_len=0.
- Simultaneous last-input handshake and pipeline flow: the last tag travels with its data. DRAIN exits only on the tagged output handshake.
- rst asserted mid-frame: all in-flight data is discarded immediately and outputs return to reset values. The first start after rst deasserts begins a clean frame.
- Counter does not wrap: maximum frame length is 2^CNT_W−1.

## Test plan
- Values, shift=8, relu=0, len=4: inputs 384, -384, 8388607, -8388608 -> out_act 2, -1, 32767, -32768. out_last only on the 4th output; done one cycle after that handshake.
- ReLU, shift=0, relu=1, len=2: inputs -5000, 5000 -> 0, 5000. With relu=0 the same inputs -> -5000, 5000.
- Shift clamp, shift=31, len=1: input 4194304 -> out_act 1 (shift treated as 23, rounded up).
- Backpressure, len=3: in_valid held high, out_ready low for 5 cycles. in_ready drops once 2 items are held. After out_ready returns, outputs arrive in order, each exactly once, with out_act stable while stalled.
- Zero length: start with cfg_len=0 -> done high the next cycle, busy stays 0, in_ready and out_valid stay 0.
- Reset mid-frame, len=4: assert rst after 2 inputs accepted -> out_valid=0 and busy=0 while rst is high, with no done pulse. A new start with len=1 and input 256 at shift=8 -> out_act 1 with out_last.
